i2s_rx: RTL and testbench

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_rx.sv | 215 +++++++++++++++++++++
 tb/tb_i2s_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
//==============================================================================
// Module      : i2s_rx
// Description : I2S receiver. Oversamples bclk/lrclk/sdata on the system
//               clock, deserialises left/right slots into DATA_WIDTH-bit
//               two's-complement words and presents each stereo pair on a
//               valid/ready output with a sticky overrun flag.
//               Optional peak meter enabled by defining I2S_RX_PEAK_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2s_rx #(
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bclk,
    input  logic                  lrclk,
    input  logic                  sdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_left,
    output logic [DATA_WIDTH-1:0] out_right,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic [DATA_WIDTH-2:0] peak_l,
    output logic [DATA_WIDTH-2:0] peak_r,
    input  logic                  peak_clr
);

    localparam logic [0:0] ST_UNSYNC = 1'b0;
    localparam logic [0:0] ST_SYNC   = 1'b1;
    localparam logic [5:0] CNT_MAX   = 6'd63;

    logic                  r_bclk_meta;
    logic                  r_bclk_sync;
    logic                  r_bclk_prev;
    logic                  r_lr_meta;
    logic                  r_lr_sync;
    logic                  r_sd_meta;
    logic                  r_sd_sync;
    logic                  r_lr_prev;
    logic [5:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [0:0]            r_state;
    logic                  r_left_present;
    logic [DATA_WIDTH-1:0] r_left_hold;

    logic                  w_rise;
    logic                  w_slot_end;
    logic [DATA_WIDTH-1:0] w_bit_mask;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_frame;
    logic                  w_accept;
    logic                  w_drop;

    // Two-flop synchronizers for the codec pins plus a delayed bclk for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bclk_meta <= 1'b0;
            r_bclk_sync <= 1'b0;
            r_bclk_prev <= 1'b0;
            r_lr_meta   <= 1'b0;
            r_lr_sync   <= 1'b0;
            r_sd_meta   <= 1'b0;
            r_sd_sync   <= 1'b0;
        end else begin
            r_bclk_meta <= bclk;
            r_bclk_sync <= r_bclk_meta;
            r_bclk_prev <= r_bclk_sync;
            r_lr_meta   <= lrclk;
            r_lr_sync   <= r_lr_meta;
            r_sd_meta   <= sdata;
            r_sd_sync   <= r_sd_meta;
        end
    end

    assign w_rise     = r_bclk_sync & ~r_bclk_prev;
    assign w_slot_end = w_rise & (r_lr_sync != r_lr_prev);

    // One-hot position of the current bit (MSB first); all-zero once the
    // counter passes DATA_WIDTH so surplus slot bits fall away
    always_comb begin
        w_bit_mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (r_cnt == 6'(DATA_WIDTH - 1 - i)) begin
                w_bit_mask[i] = 1'b1;
            end
        end
    end

    // The bit sampled on the lrclk-change rise is the ending word's LSB, so it
    // is merged into the word being latched but never into the new slot
    assign w_word = r_shift | (w_bit_mask & {DATA_WIDTH{r_sd_sync}});

    // Slot deserialiser: bit counter and left-aligned shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lr_prev <= 1'b0;
            r_cnt     <= '0;
            r_shift   <= '0;
        end else if (w_rise) begin
            r_lr_prev <= r_lr_sync;
            if (w_slot_end) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else begin
                r_cnt   <= (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + 6'd1;
                r_shift <= w_word;
            end
        end
    end

    // Slot-end state machine: first transition only establishes alignment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_UNSYNC;
            r_left_present <= 1'b0;
            r_left_hold    <= '0;
        end else if (w_slot_end) begin
            if (r_state == ST_UNSYNC) begin
                r_state <= ST_SYNC;
            end else if (r_lr_sync) begin
                r_left_hold    <= w_word;
                r_left_present <= 1'b1;
            end else begin
                r_left_present <= 1'b0;
            end
        end
    end

    assign w_frame  = w_slot_end & (r_state == ST_SYNC) & ~r_lr_sync & r_left_present;
    assign w_accept = out_valid & out_ready;
    assign w_drop   = w_frame & out_valid & ~out_ready;

    // Output holding register with valid/ready handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_left  <= '0;
            out_right <= '0;
        end else if (w_frame && (!out_valid || out_ready)) begin
            out_valid <= 1'b1;
            out_left  <= r_left_hold;
            out_right <= w_word;
        end else if (w_accept) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overrun; a fresh drop wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (w_drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

`ifdef I2S_RX_PEAK_EN
    logic [DATA_WIDTH-2:0] r_peak_l;
    logic [DATA_WIDTH-2:0] r_peak_r;
    logic [DATA_WIDTH-2:0] w_mag_l;
    logic [DATA_WIDTH-2:0] w_mag_r;
    logic [DATA_WIDTH-2:0] w_base_l;
    logic [DATA_WIDTH-2:0] w_base_r;

    // Magnitude of a two's-complement sample, most-negative saturated
    function automatic logic [DATA_WIDTH-2:0] f_mag(input logic [DATA_WIDTH-1:0] s);
        logic [DATA_WIDTH-1:0] neg;
        neg = -s;
        if (!s[DATA_WIDTH-1]) begin
            return s[DATA_WIDTH-2:0];
        end else if (s == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
            return '1;
        end else begin
            return neg[DATA_WIDTH-2:0];
        end
    endfunction

    assign w_mag_l  = f_mag(r_left_hold);
    assign w_mag_r  = f_mag(w_word);
    assign w_base_l = peak_clr ? '0 : r_peak_l;
    assign w_base_r = peak_clr ? '0 : r_peak_r;

    // Peak hold over every completed frame, stored or dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak_l <= '0;
            r_peak_r <= '0;
        end else if (w_frame) begin
            r_peak_l <= (w_mag_l > w_base_l) ? w_mag_l : w_base_l;
            r_peak_r <= (w_mag_r > w_base_r) ? w_mag_r : w_base_r;
        end else if (peak_clr) begin
            r_peak_l <= '0;
            r_peak_r <= '0;
        end
    end

    assign peak_l = r_peak_l;
    assign peak_r = r_peak_r;
`else
    logic w_unused_peak_clr;

    assign w_unused_peak_clr = peak_clr;
    assign peak_l            = '0;
    assign peak_r            = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2s_rx.sv
//==============================================================================
// Module      : tb_i2s_rx
// Description : Directed self-checking bench for i2s_rx (DATA_WIDTH = 24).
//               Drives a continuous I2S stream (1-bit delayed MSB) and
//               checks captured pairs, overrun, reset and peak behaviour.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2s_rx;

    localparam int DW = 24;

`ifdef I2S_RX_PEAK_EN
    localparam logic [31:0] EXP_PKL = 32'd5;
    localparam logic [31:0] EXP_PKR = 32'h007F_FFFF;
`else
    localparam logic [31:0] EXP_PKL = 32'd0;
    localparam logic [31:0] EXP_PKR = 32'd0;
`endif

    logic          clk;
    logic          rst_n;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_left;
    logic [DW-1:0] out_right;
    logic          overrun;
    logic          overrun_clr;
    logic [DW-2:0] peak_l;
    logic [DW-2:0] peak_r;
    logic          peak_clr;

    int            checks;
    int            errors;
    int            acc_cnt;
    logic [DW-1:0] acc_l;
    logic [DW-1:0] acc_r;
    logic          pending;

    i2s_rx #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_left    (out_left),
        .out_right   (out_right),
        .overrun     (overrun),
        .overrun_clr (overrun_clr),
        .peak_l      (peak_l),
        .peak_r      (peak_r),
        .peak_clr    (peak_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every accepted pair, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            acc_cnt = acc_cnt + 1;
            acc_l   = out_left;
            acc_r   = out_right;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Rises j0..j1-1 of a slot of nbits; rise 0 carries the previous word's LSB,
    // rise j>0 carries word bit (j-1) counted from the MSB of w
    task automatic send_range(input logic lr, input logic [31:0] w, input int nbits,
                              input int j0, input int j1);
        for (int j = j0; j < j1; j++) begin
            bclk  = 1'b0;
            lrclk = lr;
            sdata = (j == 0) ? pending : w[32 - j];
            #40;
            bclk  = 1'b1;
            #40;
        end
        if (j1 == nbits) pending = w[32 - nbits];
    endtask

    task automatic send_slot(input logic lr, input logic [31:0] w, input int nbits);
        send_range(lr, w, nbits, 0, nbits);
    endtask

    task automatic pulse_clr(input int which);
        @(posedge clk); #2;
        if (which == 0) overrun_clr = 1'b1; else peak_clr = 1'b1;
        @(posedge clk); #2;
        overrun_clr = 1'b0;
        peak_clr    = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        acc_cnt     = 0;
        acc_l       = '0;
        acc_r       = '0;
        pending     = 1'b0;
        rst_n       = 1'b0;
        bclk        = 1'b0;
        lrclk       = 1'b0;
        sdata       = 1'b0;
        out_ready   = 1'b1;
        overrun_clr = 1'b0;
        peak_clr    = 1'b0;

        repeat (3) @(posedge clk);
        #2;
        check("rst_valid",  32'(out_valid), 32'd0);
        check("rst_left",   32'(out_left),  32'd0);
        check("rst_right",  32'(out_right), 32'd0);
        check("rst_overrun",32'(overrun),   32'd0);
        check("rst_peak_l", 32'(peak_l),    32'd0);
        check("rst_peak_r", 32'(peak_r),    32'd0);
        rst_n = 1'b1;

        // Sync frame, then L=0x123456 R=0xABCDEF in 32-bit slots
        send_slot(1'b0, 32'h0000_0000, 32);
        send_slot(1'b1, 32'h0000_0000, 32);
        send_slot(1'b0, 32'h1234_5600, 32);
        send_slot(1'b1, 32'hABCD_EF00, 32);
        check("sync_no_out", 32'(acc_cnt), 32'd0);

        // 16-bit slots: L=0x8001 R=0x7FFF; the first slot closes the 32-bit frame
        send_slot(1'b0, 32'h8001_0000, 16);
        check("f32_count", 32'(acc_cnt),   32'd1);
        check("f32_left",  32'(acc_l),     32'h0012_3456);
        check("f32_right", 32'(acc_r),     32'h00AB_CDEF);
        check("f32_vdrop", 32'(out_valid), 32'd0);
        send_slot(1'b1, 32'h7FFF_0000, 16);

        // Backpressure: F1 held, F2 and F3 dropped
        send_slot(1'b0, 32'h0A0B_0C00, 32);
        check("f16_count", 32'(acc_cnt), 32'd2);
        check("f16_left",  32'(acc_l),   32'h0080_0100);
        check("f16_right", 32'(acc_r),   32'h007F_FF00);
        out_ready = 1'b0;
        send_slot(1'b1, 32'h0D0E_0F00, 32);
        send_slot(1'b0, 32'h1111_1100, 32);
        send_slot(1'b1, 32'h2222_2200, 32);
        send_slot(1'b0, 32'h3333_3300, 32);
        send_slot(1'b1, 32'h4444_4400, 32);
        send_slot(1'b0, 32'hFFFF_FB00, 32);
        check("ovr_valid", 32'(out_valid), 32'd1);
        check("ovr_left",  32'(out_left),  32'h000A_0B0C);
        check("ovr_right", 32'(out_right), 32'h000D_0E0F);
        check("ovr_flag",  32'(overrun),   32'd1);
        check("ovr_count", 32'(acc_cnt),   32'd2);
        pulse_clr(0);
        check("ovr_clr",   32'(overrun),   32'd0);
        check("ovr_hold",  32'(out_left),  32'h000A_0B0C);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("acc_count", 32'(acc_cnt),   32'd3);
        check("acc_left",  32'(acc_l),     32'h000A_0B0C);
        check("acc_right", 32'(acc_r),     32'h000D_0E0F);
        check("acc_valid", 32'(out_valid), 32'd0);

        // Peak meter: frames (-5, 3) then (2, most-negative)
        pulse_clr(1);
        check("pk_clr0_l", 32'(peak_l), 32'd0);
        check("pk_clr0_r", 32'(peak_r), 32'd0);
        send_slot(1'b1, 32'h0000_0300, 32);
        send_slot(1'b0, 32'h0000_0200, 32);
        check("neg_left",  32'(acc_l), 32'h00FF_FFFB);
        check("neg_right", 32'(acc_r), 32'h0000_0003);
        send_slot(1'b1, 32'h8000_0000, 32);
        send_slot(1'b0, 32'h0000_0000, 32);
        check("pk_count",  32'(acc_cnt), 32'd5);
        check("pk_left",   32'(acc_l),   32'h0000_0002);
        check("pk_right",  32'(acc_r),   32'h0080_0000);
        check("pk_l",      32'(peak_l),  EXP_PKL);
        check("pk_r",      32'(peak_r),  EXP_PKR);
        pulse_clr(1);
        check("pk_clr1_l", 32'(peak_l), 32'd0);
        check("pk_clr1_r", 32'(peak_r), 32'd0);

        // Reset mid right slot, release mid left slot
        send_range(1'b1, 32'h5555_5500, 32, 0, 10);
        rst_n = 1'b0;
        #10;
        check("mrst_left",  32'(out_left),  32'd0);
        check("mrst_right", 32'(out_right), 32'd0);
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_ovr",   32'(overrun),   32'd0);
        send_range(1'b1, 32'h5555_5500, 32, 10, 32);
        send_range(1'b0, 32'h6666_6600, 32, 0, 12);
        rst_n = 1'b1;
        send_range(1'b0, 32'h6666_6600, 32, 12, 32);
        send_slot(1'b1, 32'h7777_7700, 32);
        send_slot(1'b0, 32'h1212_1200, 32);
        check("post_rst_none1", 32'(acc_cnt), 32'd5);
        send_slot(1'b1, 32'h3434_3400, 32);
        check("post_rst_none2", 32'(acc_cnt), 32'd5);
        send_slot(1'b0, 32'h0000_0000, 32);
        check("post_rst_count", 32'(acc_cnt), 32'd6);
        check("post_rst_left",  32'(acc_l),   32'h0012_1212);
        check("post_rst_right", 32'(acc_r),   32'h0034_3434);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
